sensor_request_conditioner: RTL and testbench
=============================================

Name: sensor_request_conditioner

Overview:
- Upstream stage of TrafficLightTop's light-sequencing FSM.
- Turns the raw side-street sensor_button into a clean, latched side-street service request.
- Pipeline: 2-flop synchroniser, debounce filter, edge detector, req/ack handshake FSM with post-service holdoff, and a saturating count of vehicle arrivals.
- The sequencer sees only a stable side_req and answers with a one-cycle side_ack when it grants the side street green.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive masterclk cycles synchronised input must differ from filtered level before the level flips (>=1)
HOLDOFF_CYCLES, 16, cycles after an ack during which no new request is raised (>=1)
CNT_W, 8, width of pending_count

Ports:
masterclk  input  1  single system clock, rising-edge
reset_button  input  1  asynchronous, active-low reset
sensor_button  input  1  raw asynchronous vehicle sensor, active-high
side_ack  input  1  one-cycle pulse from sequencer: side street service granted
side_req  output  1  registered request to sequencer, level, held until acked
sensor_level  output  1  debounced sensor level
press_pulse  output  1  one-cycle pulse on each debounced rising edge
pending_count  output  CNT_W  arrivals since last ack, saturating
holdoff_active  output  1  high while in HOLDOFF

Behaviour:
- Reset: reset_button low asynchronously clears sync flops, debounce counter, sensor_level, press_pulse, side_req, pending_count and holdoff_active to 0, and sets the FSM to IDLE. Reset is released synchronously through normal flop behaviour.
- Reset mid-operation discards any pending request, count or holdoff.
- Synchroniser: sync1 <= sensor_button, sync2 <= sync1.
- Debounce:
  - Counter clears whenever sync2 == sensor_level.
  - Otherwise it increments.
  - When it would reach DEBOUNCE_CYCLES, sensor_level <= sync2 and the counter clears.
  - A steady input therefore flips sensor_level on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first sampling edge as 1.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never reach sensor_level.
- press_pulse: registered, high for exactly the one cycle in which sensor_level first reads 1 after a 0. Falling edges produce no pulse.
- pending_count:
  - press_pulse alone: +1, saturating at 2^CNT_W-1 (no wrap).
  - side_ack accepted in REQ: clears to 0.
  - Simultaneous accepted ack and press_pulse: loads 1.
- FSM states: IDLE, REQ, HOLDOFF.
  - IDLE: side_req=0. press_pulse -> REQ (side_req high next cycle).
  - REQ: side_req=1. side_ack -> HOLDOFF. side_req drops the next cycle and the holdoff counter loads HOLDOFF_CYCLES-1.
  - HOLDOFF: side_req=0, holdoff_active=1, counter decrements. Presses are counted but raise no request.
    - At counter==0 with pending_count>0 (including a press in that same cycle) -> REQ.
    - At counter==0 with pending_count==0 -> IDLE.
    - HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
- side_ack in IDLE or HOLDOFF: ignored; no state or count change.
- side_req is a registered output with no combinational path from side_ack.
- Latency from steady sensor press to side_req high: DEBOUNCE_CYCLES+3 edges.

Decomposition:
- Shared package tlc_pkg holds:
  - the state typedef (IDLE/REQ/HOLDOFF, 2-bit encoding);
  - default constants DEBOUNCE_CYCLES_DEF=4 and HOLDOFF_CYCLES_DEF=16;
  - the active-low reset convention.
- One sub-module, input_debouncer (synchroniser, debounce counter, edge pulse; parameter DEBOUNCE_CYCLES), reusable for the reset button path.
- The FSM and count logic stay in the top module.

Test Plan:
- Reset, then sensor_button=1 held from edge 1 (D=4, H=16) -> sensor_level and press_pulse high at edge 6; side_req high at edge 7; pending_count=1.
- 3-cycle high glitch on sensor_button -> sensor_level, press_pulse and side_req stay 0 throughout.
- In REQ, pulse side_ack one cycle -> side_req 0 the next cycle; holdoff_active high exactly 16 cycles; pending_count=0; returns to IDLE.
- Debounced press during HOLDOFF -> side_req stays 0 until holdoff ends, then rises the next cycle; pending_count=1.
- 300 clean presses with no ack (CNT_W=8) -> pending_count saturates at 255, side_req stays 1; then side_ack coincident with a press -> pending_count=1.
- Drive reset_button low mid-REQ and mid-HOLDOFF -> all outputs 0 immediately without a clock edge; after release, an old held press is re-debounced from scratch.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and defaults for the traffic-light controller input path.
package tlc_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned HOLDOFF_CYCLES_DEF  = 16;

    // All controller resets are asynchronous and active-low.
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StHoldoff = 2'b10
    } state_e;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser, consecutive-sample debounce filter and rising-edge pulse.
module input_debouncer
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            // Enough consecutive differing samples: accept the new level.
            level_d = sync_q[1];
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (rst_ni == RST_ACTIVE) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/sensor_request_conditioner.sv
// Conditions the side-street sensor into a latched req/ack request with post-service holdoff
// and a saturating count of vehicle arrivals.
module sensor_request_conditioner
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             masterclk,
    input  logic             reset_button,
    input  logic             sensor_button,
    input  logic             side_ack,
    output logic             side_req,
    output logic             sensor_level,
    output logic             press_pulse,
    output logic [CNT_W-1:0] pending_count,
    output logic             holdoff_active
);

    localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF_CYCLES - 1);

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic             side_req_q, holdoff_q;
    logic             press;
    logic             ack_accepted;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sensor_debouncer (
        .clk_i  (masterclk),
        .rst_ni (reset_button),
        .din_i  (sensor_button),
        .level_o(sensor_level),
        .rise_o (press)
    );

    assign ack_accepted = (state_q == StReq) && side_ack;
    assign count_inc    = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (press) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (side_ack) begin
                    state_d = StHoldoff;
                    hold_d  = HoldLoad;
                end
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    // Arrivals seen during holdoff (or right now) are served immediately.
                    state_d = ((count_q != '0) || press) ? StReq : StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (ack_accepted) begin
            count_d = press ? CNT_W'(1) : '0;
        end else if (press) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge masterclk or negedge reset_button) begin
        if (reset_button == RST_ACTIVE) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            count_q    <= '0;
            side_req_q <= 1'b0;
            holdoff_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            side_req_q <= (state_d == StReq);
            holdoff_q  <= (state_d == StHoldoff);
        end
    end

    assign side_req       = side_req_q;
    assign press_pulse    = press;
    assign pending_count  = count_q;
    assign holdoff_active = holdoff_q;

endmodule

// File: tb/tb_sensor_request_conditioner.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor checks them.
module tb_sensor_request_conditioner;

    localparam int SIG_REQ   = 0;
    localparam int SIG_LEVEL = 1;
    localparam int SIG_PULSE = 2;
    localparam int SIG_COUNT = 3;
    localparam int SIG_HOLD  = 4;

    logic       masterclk;
    logic       reset_button;
    logic       sensor_button;
    logic       side_ack;
    logic       side_req;
    logic       sensor_level;
    logic       press_pulse;
    logic [7:0] pending_count;
    logic       holdoff_active;

    typedef struct {
        string name;
        int    cyc;
        int    sig;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    event chk_now;

    sensor_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .masterclk     (masterclk),
        .reset_button  (reset_button),
        .sensor_button (sensor_button),
        .side_ack      (side_ack),
        .side_req      (side_req),
        .sensor_level  (sensor_level),
        .press_pulse   (press_pulse),
        .pending_count (pending_count),
        .holdoff_active(holdoff_active)
    );

    initial masterclk = 1'b0;
    always #5 masterclk = ~masterclk;

    always @(posedge masterclk) edge_cnt <= edge_cnt + 1;

    function automatic int sample(input int sig);
        case (sig)
            SIG_REQ:   return int'(side_req);
            SIG_LEVEL: return int'(sensor_level);
            SIG_PULSE: return int'(press_pulse);
            SIG_COUNT: return int'(pending_count);
            default:   return int'(holdoff_active);
        endcase
    endfunction

    task automatic scan(input int tag);
        int act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == tag) begin
                act = sample(sb[i].sig);
                checks++;
                if (act != sb[i].val) begin
                    errors++;
                    $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                             sb[i].name, act, sb[i].val, tag);
                end
                sb.delete(i);
            end else if (tag >= 0 && sb[i].cyc >= 0 && sb[i].cyc < tag) begin
                checks++;
                errors++;
                $display("FAIL %s: never sampled, expected %0d at edge %0d",
                         sb[i].name, sb[i].val, sb[i].cyc);
                sb.delete(i);
            end
        end
    endtask

    // Monitor: clocked expectations on the falling edge, immediate ones on request.
    always @(negedge masterclk) scan(edge_cnt);

    always begin
        @(chk_now);
        scan(-1);
    end

    task automatic expect_at(input string n, input int k, input int sig, input int val);
        exp_t e;
        e.name = n;
        e.cyc  = edge_cnt + k;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_now(input string n, input int sig, input int val);
        exp_t e;
        e.name = n;
        e.cyc  = -1;
        e.sig  = sig;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge masterclk);
            #1;
        end
    endtask

    task automatic expect_all_zero_now(input string n);
        expect_now({n, "_req"}, SIG_REQ, 0);
        expect_now({n, "_level"}, SIG_LEVEL, 0);
        expect_now({n, "_pulse"}, SIG_PULSE, 0);
        expect_now({n, "_count"}, SIG_COUNT, 0);
        expect_now({n, "_holdoff"}, SIG_HOLD, 0);
        ->chk_now;
    endtask

    // Called right after reset release with sensor_button already high.
    task automatic expect_fresh_press(input string n);
        expect_at({n, "_level_e5"}, 5, SIG_LEVEL, 0);
        expect_at({n, "_level_e6"}, 6, SIG_LEVEL, 1);
        expect_at({n, "_pulse_e5"}, 5, SIG_PULSE, 0);
        expect_at({n, "_pulse_e6"}, 6, SIG_PULSE, 1);
        expect_at({n, "_pulse_e7"}, 7, SIG_PULSE, 0);
        expect_at({n, "_req_e6"}, 6, SIG_REQ, 0);
        expect_at({n, "_req_e7"}, 7, SIG_REQ, 1);
        expect_at({n, "_count_e6"}, 6, SIG_COUNT, 0);
        expect_at({n, "_count_e7"}, 7, SIG_COUNT, 1);
        expect_at({n, "_holdoff_e7"}, 7, SIG_HOLD, 0);
    endtask

    task automatic pulse_reset(input string n);
        reset_button = 1'b0;
        #2;
        expect_all_zero_now(n);
        tick(1);
        reset_button = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset_button  = 1'b0;
        sensor_button = 1'b0;
        side_ack      = 1'b0;
        tick(3);
        expect_all_zero_now("reset");

        // Steady press from edge 1 after release.
        reset_button  = 1'b1;
        sensor_button = 1'b1;
        expect_fresh_press("press1");
        tick(9);

        // Ack in REQ, then a 16-cycle holdoff back to IDLE.
        expect_at("req_before_ack", 0, SIG_REQ, 1);
        side_ack = 1'b1;
        tick(1);
        side_ack = 1'b0;
        expect_at("ack_req_drop", 0, SIG_REQ, 0);
        expect_at("ack_count_clear", 0, SIG_COUNT, 0);
        for (int k = 0; k < 16; k++) expect_at("holdoff_window", k, SIG_HOLD, 1);
        expect_at("holdoff_end", 16, SIG_HOLD, 0);
        expect_at("idle_req_e16", 16, SIG_REQ, 0);
        expect_at("idle_req_e17", 17, SIG_REQ, 0);
        tick(18);

        // Ack in IDLE is ignored.
        side_ack = 1'b1;
        tick(1);
        side_ack = 1'b0;
        expect_at("idle_ack_req", 0, SIG_REQ, 0);
        expect_at("idle_ack_req_next", 1, SIG_REQ, 0);
        expect_at("idle_ack_count", 0, SIG_COUNT, 0);
        expect_at("idle_ack_holdoff", 1, SIG_HOLD, 0);
        tick(2);

        // Release, then a 3-cycle glitch that must never be seen.
        sensor_button = 1'b0;
        tick(10);
        expect_at("release_level", 0, SIG_LEVEL, 0);
        sensor_button = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_at("glitch_level", k, SIG_LEVEL, 0);
            expect_at("glitch_pulse", k, SIG_PULSE, 0);
            expect_at("glitch_req", k, SIG_REQ, 0);
        end
        tick(3);
        sensor_button = 1'b0;
        tick(12);

        // Request, ack, then a press during holdoff.
        sensor_button = 1'b1;
        expect_at("hp_pulse", 6, SIG_PULSE, 1);
        expect_at("hp_req", 7, SIG_REQ, 1);
        expect_at("hp_count", 7, SIG_COUNT, 1);
        tick(7);
        sensor_button = 1'b0;
        tick(7);
        side_ack = 1'b1;
        tick(1);
        side_ack = 1'b0;
        expect_at("hp_ack_req", 0, SIG_REQ, 0);
        expect_at("hp_ack_holdoff", 0, SIG_HOLD, 1);
        expect_at("hp_ack_count", 0, SIG_COUNT, 0);
        tick(1);
        sensor_button = 1'b1;
        expect_at("hold_press_pulse", 6, SIG_PULSE, 1);
        expect_at("hold_press_count", 7, SIG_COUNT, 1);
        expect_at("hold_press_req_e7", 7, SIG_REQ, 0);
        expect_at("hold_press_req_e14", 14, SIG_REQ, 0);
        expect_at("hold_press_hold_e14", 14, SIG_HOLD, 1);
        expect_at("hold_press_req_e15", 15, SIG_REQ, 1);
        expect_at("hold_press_hold_e15", 15, SIG_HOLD, 0);
        expect_at("hold_press_count_e15", 15, SIG_COUNT, 1);
        tick(16);
        sensor_button = 1'b0;
        tick(8);

        // 300 clean presses with no ack: count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            sensor_button = 1'b1;
            tick(6);
            sensor_button = 1'b0;
            tick(6);
            if (i == 10)  expect_at("sat_count_10", 0, SIG_COUNT, 11);
            if (i == 253) expect_at("sat_count_253", 0, SIG_COUNT, 254);
            if (i == 254) expect_at("sat_count_254", 0, SIG_COUNT, 255);
            if (i == 300) begin
                expect_at("sat_count_300", 0, SIG_COUNT, 255);
                expect_at("sat_req", 0, SIG_REQ, 1);
            end
        end

        // Ack coincident with a press loads 1.
        sensor_button = 1'b1;
        tick(6);
        expect_at("coinc_pulse", 0, SIG_PULSE, 1);
        side_ack = 1'b1;
        tick(1);
        side_ack = 1'b0;
        expect_at("coinc_count", 0, SIG_COUNT, 1);
        expect_at("coinc_req", 0, SIG_REQ, 0);
        expect_at("coinc_holdoff", 0, SIG_HOLD, 1);
        tick(3);

        // Reset mid-HOLDOFF with the sensor still held: re-debounced from scratch.
        pulse_reset("rst_holdoff");
        expect_fresh_press("after_rst_holdoff");
        tick(9);

        // Reset mid-REQ.
        expect_at("req_before_rst", 0, SIG_REQ, 1);
        tick(1);
        pulse_reset("rst_req");
        expect_fresh_press("after_rst_req");
        tick(10);
        sensor_button = 1'b0;
        tick(10);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
